wb_burst_master: RTL and testbench

WB_BURST_MASTER -- requirements
Module: wb_burst_master

---
 rtl/wb_burst_master.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// Wishbone B4 registered-feedback burst master: takes one command at a time,
// streams write data in or read data out, and reports completion status.
module wb_burst_master #(
    parameter int dw = 32,
    parameter int aw = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [aw-1:0]     cmd_adr_i,
    input  logic              cmd_we_i,
    input  logic [3:0]        cmd_len_i,
    input  logic [1:0]        cmd_bte_i,
    input  logic [dw/8-1:0]   cmd_sel_i,
    input  logic [dw-1:0]     wdata_i,
    input  logic              wdata_valid_i,
    output logic              wdata_ready_o,
    output logic [dw-1:0]     rdata_o,
    output logic              rdata_valid_o,
    output logic              done_o,
    output logic [1:0]        status_o,
    output logic [aw-1:0]     wb_adr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic [2:0]        wb_cti_o,
    output logic [1:0]        wb_bte_o,
    input  logic [dw-1:0]     wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i
);

    localparam int SW = dw / 8;
    localparam logic [aw-1:0] STEP  = aw'(SW);
    localparam logic [aw-1:0] MASK4 = aw'(4 * SW - 1);
    localparam logic [aw-1:0] MASK8 = aw'(8 * SW - 1);
    localparam logic [aw-1:0] MASK16 = aw'(16 * SW - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WDATA  = 2'd1,
        ACTIVE = 2'd2,
        RETRY  = 2'd3
    } state_t;

    // Wrapping bursts keep the address bits above the block fixed; linear
    // bursts use an all-ones mask so the plain increment passes through.
    function automatic logic [aw-1:0] next_adr(input logic [aw-1:0] adr,
                                               input logic [1:0]    bte);
        logic [aw-1:0] inc;
        logic [aw-1:0] mask;
        inc = adr + STEP;
        case (bte)
            2'b01:   mask = MASK4;
            2'b10:   mask = MASK8;
            2'b11:   mask = MASK16;
            default: mask = {aw{1'b1}};
        endcase
        return (adr & ~mask) | (inc & mask);
    endfunction

    function automatic logic [2:0] cti_for(input logic burst, input logic [3:0] rem);
        logic [2:0] cti;
        if (!burst) begin
            cti = 3'b000;
        end else if (rem == 4'd0) begin
            cti = 3'b111;
        end else begin
            cti = 3'b010;
        end
        return cti;
    endfunction

    state_t state_r, state_s;

    logic [aw-1:0]   adr_r, adr_s;
    logic [dw-1:0]   dat_r, dat_s;
    logic [dw/8-1:0] sel_r, sel_s;
    logic            we_r, we_s;
    logic            cyc_r, cyc_s;
    logic            stb_r, stb_s;
    logic [2:0]      cti_r, cti_s;
    logic [1:0]      bte_out_r, bte_out_s;
    logic [1:0]      bte_r, bte_s;
    logic            burst_r, burst_s;
    logic [3:0]      rem_r, rem_s;
    logic [dw-1:0]   rdata_r, rdata_s;
    logic            rdata_valid_r, rdata_valid_s;
    logic            done_r, done_s;
    logic [1:0]      status_r, status_s;

    logic accept_s;
    logic beat_err_s;
    logic beat_rty_s;
    logic beat_ack_s;
    logic last_s;
    logic load_s;

    // Handshake and bus-response decode; err beats rty beats ack, all gated by stb.
    always_comb begin
        accept_s      = cmd_valid_i & cmd_ready_o;
        beat_err_s    = stb_r & wb_err_i;
        beat_rty_s    = stb_r & wb_rty_i & ~wb_err_i;
        beat_ack_s    = stb_r & wb_ack_i & ~wb_err_i & ~wb_rty_i;
        last_s        = (rem_r == 4'd0);
        wdata_ready_o = (state_r == WDATA) ||
                        ((state_r == ACTIVE) && we_r && beat_ack_s && !last_s);
        load_s        = wdata_valid_i & wdata_ready_o;
    end

    assign cmd_ready_o = (state_r == IDLE) && wb_rst_ni;

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = cmd_we_i ? WDATA : ACTIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            WDATA: begin
                if (load_s) begin
                    state_s = ACTIVE;
                end else begin
                    state_s = WDATA;
                end
            end
            ACTIVE: begin
                if (beat_err_s) begin
                    state_s = IDLE;
                end else if (beat_rty_s) begin
                    state_s = RETRY;
                end else if (beat_ack_s) begin
                    if (last_s) begin
                        state_s = IDLE;
                    end else if (we_r && !wdata_valid_i) begin
                        state_s = WDATA;
                    end else begin
                        state_s = ACTIVE;
                    end
                end else begin
                    state_s = ACTIVE;
                end
            end
            RETRY:   state_s = ACTIVE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of every registered output and the burst bookkeeping.
    always_comb begin
        adr_s         = adr_r;
        dat_s         = dat_r;
        sel_s         = sel_r;
        we_s          = we_r;
        cyc_s         = cyc_r;
        stb_s         = stb_r;
        cti_s         = cti_r;
        bte_out_s     = bte_out_r;
        bte_s         = bte_r;
        burst_s       = burst_r;
        rem_s         = rem_r;
        rdata_s       = rdata_r;
        rdata_valid_s = 1'b0;
        done_s        = 1'b0;
        status_s      = status_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    adr_s     = cmd_adr_i;
                    we_s      = cmd_we_i;
                    sel_s     = cmd_sel_i;
                    bte_s     = cmd_bte_i;
                    burst_s   = (cmd_len_i != 4'd0);
                    rem_s     = cmd_len_i;
                    cyc_s     = 1'b1;
                    stb_s     = ~cmd_we_i;
                    cti_s     = cti_for(cmd_len_i != 4'd0, cmd_len_i);
                    bte_out_s = (cmd_len_i != 4'd0) ? cmd_bte_i : 2'b00;
                end else begin
                    cyc_s = 1'b0;
                    stb_s = 1'b0;
                end
            end
            WDATA: begin
                if (load_s) begin
                    dat_s = wdata_i;
                    stb_s = 1'b1;
                end else begin
                    stb_s = 1'b0;
                end
            end
            ACTIVE: begin
                if (beat_err_s) begin
                    cyc_s    = 1'b0;
                    stb_s    = 1'b0;
                    done_s   = 1'b1;
                    status_s = 2'b01;
                end else if (beat_rty_s) begin
                    cyc_s = 1'b0;
                    stb_s = 1'b0;
                end else if (beat_ack_s) begin
                    if (!we_r) begin
                        rdata_s       = wb_dat_i;
                        rdata_valid_s = 1'b1;
                    end else begin
                        rdata_valid_s = 1'b0;
                    end
                    if (last_s) begin
                        cyc_s    = 1'b0;
                        stb_s    = 1'b0;
                        done_s   = 1'b1;
                        status_s = 2'b00;
                    end else begin
                        adr_s = next_adr(adr_r, bte_r);
                        rem_s = rem_r - 4'd1;
                        cti_s = cti_for(burst_r, rem_r - 4'd1);
                        if (!we_r) begin
                            stb_s = 1'b1;
                        end else if (load_s) begin
                            dat_s = wdata_i;
                            stb_s = 1'b1;
                        end else begin
                            stb_s = 1'b0;
                        end
                    end
                end else begin
                    stb_s = stb_r;
                end
            end
            RETRY: begin
                cyc_s = 1'b1;
                stb_s = 1'b1;
                cti_s = cti_for(burst_r, rem_r);
            end
            default: begin
                cyc_s = 1'b0;
                stb_s = 1'b0;
            end
        endcase
    end

    // Output and bookkeeping registers; reset drops the bus cycle immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            adr_r         <= {aw{1'b0}};
            dat_r         <= {dw{1'b0}};
            sel_r         <= {(dw/8){1'b0}};
            we_r          <= 1'b0;
            cyc_r         <= 1'b0;
            stb_r         <= 1'b0;
            cti_r         <= 3'b000;
            bte_out_r     <= 2'b00;
            bte_r         <= 2'b00;
            burst_r       <= 1'b0;
            rem_r         <= 4'd0;
            rdata_r       <= {dw{1'b0}};
            rdata_valid_r <= 1'b0;
            done_r        <= 1'b0;
            status_r      <= 2'b00;
        end else begin
            adr_r         <= adr_s;
            dat_r         <= dat_s;
            sel_r         <= sel_s;
            we_r          <= we_s;
            cyc_r         <= cyc_s;
            stb_r         <= stb_s;
            cti_r         <= cti_s;
            bte_out_r     <= bte_out_s;
            bte_r         <= bte_s;
            burst_r       <= burst_s;
            rem_r         <= rem_s;
            rdata_r       <= rdata_s;
            rdata_valid_r <= rdata_valid_s;
            done_r        <= done_s;
            status_r      <= status_s;
        end
    end

    assign wb_adr_o      = adr_r;
    assign wb_dat_o      = dat_r;
    assign wb_sel_o      = sel_r;
    assign wb_we_o       = we_r;
    assign wb_cyc_o      = cyc_r;
    assign wb_stb_o      = stb_r;
    assign wb_cti_o      = cti_r;
    assign wb_bte_o      = bte_out_r;
    assign rdata_o       = rdata_r;
    assign rdata_valid_o = rdata_valid_r;
    assign done_o        = done_r;
    assign status_o      = status_r;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: the slave side is driven step by step
// with hand-computed expectations for addresses, cti, data and status.
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_adr = 32'd0;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_len = 4'd0;
    logic [1:0]  cmd_bte = 2'd0;
    logic [3:0]  cmd_sel = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic [1:0]  status;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_i = 32'd0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic        wb_rty = 1'b0;

    int tests = 0;
    int fails = 0;

    wb_burst_master #(.dw(32), .aw(32)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_adr_i(cmd_adr),
        .cmd_we_i(cmd_we), .cmd_len_i(cmd_len), .cmd_bte_i(cmd_bte), .cmd_sel_i(cmd_sel),
        .wdata_i(wdata), .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
        .rdata_o(rdata), .rdata_valid_o(rdata_valid), .done_o(done), .status_o(status),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] adr, input logic we, input logic [3:0] len,
                         input logic [1:0] bte);
        cmd_adr   = adr;
        cmd_we    = we;
        cmd_len   = len;
        cmd_bte   = bte;
        cmd_sel   = 4'hF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_cyc", wb_cyc, 1'b0);
        chk("rst_stb", wb_stb, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cti", wb_cti, 3'b000);
        chk("rst_ready_low", cmd_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", cmd_ready, 1'b1);

        // Single read, slave acks after two cycles
        issue(32'h100, 1'b0, 4'd0, 2'b00);
        chk("sr_cyc", wb_cyc, 1'b1);
        chk("sr_stb", wb_stb, 1'b1);
        chk("sr_cti", wb_cti, 3'b000);
        chk("sr_adr", wb_adr, 32'h100);
        chk("sr_sel", wb_sel, 4'hF);
        chk("sr_ready_busy", cmd_ready, 1'b0);
        tick();
        tick();
        chk("sr_wait_stb", wb_stb, 1'b1);
        chk("sr_wait_rv", rdata_valid, 1'b0);
        wb_ack = 1'b1;
        wb_dat_i = 32'hDEADBEEF;
        tick();
        wb_ack = 1'b0;
        chk("sr_rv", rdata_valid, 1'b1);
        chk("sr_rdata", rdata, 32'hDEADBEEF);
        chk("sr_done", done, 1'b1);
        chk("sr_status", status, 2'b00);
        chk("sr_cyc_end", wb_cyc, 1'b0);
        tick();
        chk("sr_rv_pulse", rdata_valid, 1'b0);
        chk("sr_done_pulse", done, 1'b0);
        chk("sr_ready_again", cmd_ready, 1'b1);

        // Four-beat linear write, data always valid, zero-wait acks
        wdata_valid = 1'b1;
        wdata = 32'hA0;
        issue(32'h200, 1'b1, 4'd3, 2'b00);
        chk("lw_cyc_wdata", wb_cyc, 1'b1);
        chk("lw_stb_wdata", wb_stb, 1'b0);
        chk("lw_wready", wdata_ready, 1'b1);
        tick();
        wb_ack = 1'b1;
        wdata = 32'hA1;
        #1;
        chk("lw_adr0", wb_adr, 32'h200);
        chk("lw_dat0", wb_dat_o, 32'hA0);
        chk("lw_cti0", wb_cti, 3'b010);
        chk("lw_we", wb_we, 1'b1);
        chk("lw_wready_ack", wdata_ready, 1'b1);
        tick();
        wdata = 32'hA2;
        chk("lw_adr1", wb_adr, 32'h204);
        chk("lw_dat1", wb_dat_o, 32'hA1);
        chk("lw_cti1", wb_cti, 3'b010);
        tick();
        wdata = 32'hA3;
        chk("lw_adr2", wb_adr, 32'h208);
        chk("lw_dat2", wb_dat_o, 32'hA2);
        chk("lw_cti2", wb_cti, 3'b010);
        tick();
        chk("lw_adr3", wb_adr, 32'h20C);
        chk("lw_dat3", wb_dat_o, 32'hA3);
        chk("lw_cti3", wb_cti, 3'b111);
        chk("lw_cyc3", wb_cyc, 1'b1);
        chk("lw_wready_last", wdata_ready, 1'b0);
        tick();
        wb_ack = 1'b0;
        wdata_valid = 1'b0;
        chk("lw_done", done, 1'b1);
        chk("lw_cyc_end", wb_cyc, 1'b0);
        chk("lw_status", status, 2'b00);
        tick();

        // Four-beat read, 4-beat wrap starting at 0x108
        issue(32'h108, 1'b0, 4'd3, 2'b01);
        chk("wr_adr0", wb_adr, 32'h108);
        chk("wr_bte", wb_bte, 2'b01);
        wb_ack = 1'b1;
        wb_dat_i = 32'h1;
        tick();
        chk("wr_rdata0", rdata, 32'h1);
        chk("wr_rv0", rdata_valid, 1'b1);
        chk("wr_adr1", wb_adr, 32'h10C);
        wb_dat_i = 32'h2;
        tick();
        chk("wr_rdata1", rdata, 32'h2);
        chk("wr_adr2", wb_adr, 32'h100);
        wb_dat_i = 32'h3;
        tick();
        chk("wr_adr3", wb_adr, 32'h104);
        chk("wr_cti3", wb_cti, 3'b111);
        wb_dat_i = 32'h4;
        tick();
        wb_ack = 1'b0;
        chk("wr_rdata3", rdata, 32'h4);
        chk("wr_done", done, 1'b1);
        tick();

        // Two-beat write with a three-cycle data gap and a stray ack in the gap
        wdata_valid = 1'b1;
        wdata = 32'hB0;
        issue(32'h300, 1'b1, 4'd1, 2'b00);
        tick();
        wdata_valid = 1'b0;
        wb_ack = 1'b1;
        chk("gw_stb0", wb_stb, 1'b1);
        chk("gw_dat0", wb_dat_o, 32'hB0);
        tick();
        chk("gw_gap_stb", wb_stb, 1'b0);
        chk("gw_gap_cyc", wb_cyc, 1'b1);
        chk("gw_gap_adr", wb_adr, 32'h304);
        chk("gw_gap_cti", wb_cti, 3'b111);
        tick();
        wb_ack = 1'b0;
        chk("gw_stray_adr", wb_adr, 32'h304);
        chk("gw_stray_done", done, 1'b0);
        chk("gw_stray_stb", wb_stb, 1'b0);
        tick();
        wdata_valid = 1'b1;
        wdata = 32'hB1;
        tick();
        wdata_valid = 1'b0;
        wb_ack = 1'b1;
        chk("gw_stb1", wb_stb, 1'b1);
        chk("gw_dat1", wb_dat_o, 32'hB1);
        chk("gw_adr1", wb_adr, 32'h304);
        tick();
        wb_ack = 1'b0;
        chk("gw_done", done, 1'b1);
        chk("gw_cyc_end", wb_cyc, 1'b0);
        tick();

        // Error on beat 2 of a four-beat read, ack asserted alongside err
        issue(32'h400, 1'b0, 4'd3, 2'b00);
        wb_ack = 1'b1;
        wb_dat_i = 32'h11;
        tick();
        chk("er_rv0", rdata_valid, 1'b1);
        chk("er_rdata0", rdata, 32'h11);
        wb_err = 1'b1;
        wb_dat_i = 32'h99;
        tick();
        wb_ack = 1'b0;
        wb_err = 1'b0;
        chk("er_rv1", rdata_valid, 1'b0);
        chk("er_cyc", wb_cyc, 1'b0);
        chk("er_done", done, 1'b1);
        chk("er_status", status, 2'b01);
        tick();
        chk("er_idle_ready", cmd_ready, 1'b1);

        // Retry on beat 1 of a two-beat read
        issue(32'h500, 1'b0, 4'd1, 2'b00);
        wb_rty = 1'b1;
        tick();
        wb_rty = 1'b0;
        chk("rt_cyc_low", wb_cyc, 1'b0);
        chk("rt_stb_low", wb_stb, 1'b0);
        chk("rt_done_low", done, 1'b0);
        tick();
        chk("rt_cyc_back", wb_cyc, 1'b1);
        chk("rt_adr", wb_adr, 32'h500);
        chk("rt_cti", wb_cti, 3'b010);
        wb_ack = 1'b1;
        wb_dat_i = 32'h22;
        tick();
        chk("rt_rdata0", rdata, 32'h22);
        chk("rt_adr1", wb_adr, 32'h504);
        wb_dat_i = 32'h33;
        tick();
        wb_ack = 1'b0;
        chk("rt_rdata1", rdata, 32'h33);
        chk("rt_done", done, 1'b1);
        chk("rt_status", status, 2'b00);
        tick();

        // Reset in the middle of a write burst
        wdata_valid = 1'b1;
        wdata = 32'hC0;
        issue(32'h600, 1'b1, 4'd3, 2'b00);
        tick();
        wdata_valid = 1'b0;
        chk("mr_stb_before", wb_stb, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_cyc_async", wb_cyc, 1'b0);
        chk("mr_stb_async", wb_stb, 1'b0);
        tick();
        chk("mr_no_done", done, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("mr_ready", cmd_ready, 1'b1);
        issue(32'h700, 1'b0, 4'd0, 2'b00);
        chk("mr_adr", wb_adr, 32'h700);
        wb_ack = 1'b1;
        wb_dat_i = 32'h77;
        tick();
        wb_ack = 1'b0;
        chk("mr_rdata", rdata, 32'h77);
        chk("mr_done", done, 1'b1);
        chk("mr_status", status, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
